sat_accum: RTL and testbench

- Multi-lane, parametrised successor of the combinational saturating adder.
- Accumulates a runtime-length frame of signed samples per lane, saturating at every add.
- Presents the per-lane results behind a valid/ready handshake.
- Sits between spin/field producers and downstream update logic wherever bounded running sums are needed.

---
 rtl/sat_accum_pkg.sv | 14 +
 rtl/sat_add.sv | 31 +++
 rtl/sat_accum.sv | 116 +++++++++++
 tb/tb_sat_accum.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_accum_pkg.sv
// Shared types and saturation limits for the sat_accum lane accumulator.
package sat_accum_pkg;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add: OUTW-bit signed accumulator plus sign-extended INW-bit sample.
module sat_add
  import sat_accum_pkg::*;
#(
  parameter int INW  = 8,
  parameter int OUTW = 16
) (
  input  logic signed [OUTW-1:0] a,
  input  logic signed [INW-1:0]  b,
  output logic signed [OUTW-1:0] y,
  output logic                   clamp
);

  localparam logic signed [OUTW:0] HI = (OUTW + 1)'(sat_max(OUTW));
  localparam logic signed [OUTW:0] LO = (OUTW + 1)'(sat_min(OUTW));

  logic signed [OUTW:0] sum;

  // One extra bit holds the exact sum of two in-range operands.
  assign sum = $signed({a[OUTW-1], a}) + $signed({{(OUTW + 1 - INW){b[INW-1]}}, b});

  function automatic logic signed [OUTW-1:0] clamp_to_out(input logic signed [OUTW:0] s);
    if (s > HI) return HI[OUTW-1:0];
    if (s < LO) return LO[OUTW-1:0];
    return s[OUTW-1:0];
  endfunction

  assign y     = clamp_to_out(sum);
  assign clamp = (sum > HI) || (sum < LO);

endmodule

// File: rtl/sat_accum.sv
// Multi-lane saturating frame accumulator with valid/ready result handshake.
// Define SAT_ACCUM_FLAG_EN to add the sticky per-lane sat_flag_o output.
module sat_accum
  import sat_accum_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATAW  = 8,
  parameter int ACCW   = 16,
  parameter int LENW   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [LENW-1:0]          len_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [NUM_CH*DATAW-1:0]  in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM_CH*ACCW-1:0]   out_data_o
`ifdef SAT_ACCUM_FLAG_EN
  ,
  output logic [NUM_CH-1:0]        sat_flag_o
`endif
);

  if (ACCW < DATAW) begin : g_width_check
    $fatal(1, "sat_accum: ACCW must be >= DATAW");
  end

  state_t                  state;
  logic [LENW-1:0]         cnt;
  logic [LENW-1:0]         len_q;
  logic [LENW-1:0]         len_first;
  logic signed [ACCW-1:0]  acc  [NUM_CH];
  logic signed [ACCW-1:0]  a_op [NUM_CH];
  logic signed [ACCW-1:0]  sum  [NUM_CH];
  logic [NUM_CH-1:0]       clamp;
  logic                    accept;
  logic                    last;

  assign in_ready_o = (state != OUT);
  assign accept     = in_valid_i & in_ready_o;
  assign len_first  = (len_i == '0) ? LENW'(1) : len_i;

  always_comb begin
    last = 1'b0;
    if (state == IDLE) last = (len_first == LENW'(1));
    else               last = ((cnt + LENW'(1)) == len_q);
  end

  // The first beat of a frame adds onto zero, so load and accumulate share one adder.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign a_op[c] = (state == IDLE) ? '0 : acc[c];
    sat_add #(.INW(DATAW), .OUTW(ACCW)) u_add (
      .a     (a_op[c]),
      .b     (in_data_i[c*DATAW +: DATAW]),
      .y     (sum[c]),
      .clamp (clamp[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
`ifdef SAT_ACCUM_FLAG_EN
      sat_flag_o  <= '0;
`endif
      if (rst_i) len_q <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            for (int c = 0; c < NUM_CH; c++) acc[c] <= sum[c];
            if (state == IDLE) begin
              len_q <= len_first;
              cnt   <= LENW'(1);
`ifdef SAT_ACCUM_FLAG_EN
              sat_flag_o <= clamp;
`endif
            end else begin
              cnt <= cnt + LENW'(1);
`ifdef SAT_ACCUM_FLAG_EN
              sat_flag_o <= sat_flag_o | clamp;
`endif
            end
            if (last) begin
              state       <= OUT;
              out_valid_o <= 1'b1;
              for (int c = 0; c < NUM_CH; c++) out_data_o[c*ACCW +: ACCW] <= sum[c];
            end else begin
              state <= ACC;
            end
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SAT_ACCUM_FLAG_EN
  logic unused_clamp;
  assign unused_clamp = ^clamp;
`endif

endmodule

// File: tb/tb_sat_accum.sv
// Directed self-checking bench for sat_accum (2 lanes, 8-bit samples, 8-bit sums).
module tb_sat_accum;

  localparam int NUM_CH = 2;
  localparam int DATAW  = 8;
  localparam int ACCW   = 8;
  localparam int LENW   = 8;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [7:0]  len;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
`ifdef SAT_ACCUM_FLAG_EN
  logic [1:0]  sat_flag;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sat_accum #(.NUM_CH(NUM_CH), .DATAW(DATAW), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .len_i       (len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef SAT_ACCUM_FLAG_EN
    ,
    .sat_flag_o  (sat_flag)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input int l0, input int l1);
    logic [7:0] a, b;
    a = l0[7:0];
    b = l1[7:0];
    return {b, a};
  endfunction

  task automatic beat(input int l0, input int l1, input int ln);
    int n;
    n = 0;
    in_data  = pk(l0, l1);
    len      = ln[7:0];
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL beat_ready_timeout got=%b want=1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic take;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = 8'd0; in_data = 16'h0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++;
    if (out_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h want=0000", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
`ifdef SAT_ACCUM_FLAG_EN
    checks++;
    if (sat_flag !== 2'b00) begin failures++; $display("FAIL reset_flag got=%b want=00", sat_flag); end
`endif
  endtask

  task automatic test_pos_sat;
    beat(100, -5, 3);
    beat(20, -3, 3);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL possat_early_valid got=%b want=0", out_valid); end
    beat(10, 2, 3);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL possat_valid got=%b want=1", out_valid); end
    checks++;
    if (out_data !== pk(127, -6)) begin failures++; $display("FAIL possat_data got=%h want=%h", out_data, pk(127, -6)); end
`ifdef SAT_ACCUM_FLAG_EN
    checks++;
    if (sat_flag !== 2'b01) begin failures++; $display("FAIL possat_flag got=%b want=01", sat_flag); end
`endif
    take();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL possat_handshake got=%b want=0", out_valid); end
  endtask

  task automatic test_order;
    beat(-100, 0, 3);
    beat(-100, 0, 3);
    beat(50, 0, 3);
    checks++;
    if (out_data !== pk(-78, 0)) begin failures++; $display("FAIL order_data got=%h want=%h", out_data, pk(-78, 0)); end
`ifdef SAT_ACCUM_FLAG_EN
    checks++;
    if (sat_flag !== 2'b01) begin failures++; $display("FAIL order_flag got=%b want=01", sat_flag); end
`endif
    take();
  endtask

  task automatic test_backpressure;
    beat(5, 6, 1);
    in_data  = pk(9, 9);
    len      = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_data !== pk(5, 6) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%h/%b want=%h/1", i, out_data, out_valid, pk(5, 6));
      end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, in_ready); end
      step();
    end
    take();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_handshake got=%b want=0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== pk(9, 9)) begin
      failures++;
      $display("FAIL bp_held_beat got=%h/%b want=%h/1", out_data, out_valid, pk(9, 9));
    end
    take();
  endtask

  task automatic test_len_zero;
    beat(7, -7, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== pk(7, -7)) begin
      failures++;
      $display("FAIL len0 got=%h/%b want=%h/1", out_data, out_valid, pk(7, -7));
    end
    take();
  endtask

  task automatic test_abort;
    beat(10, 10, 4);
    clear = 1'b1; in_valid = 1'b1; in_data = pk(20, 20);
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    beat(1, 1, 2);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_early_valid got=%b want=0", out_valid); end
    beat(2, 2, 2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== pk(3, 3)) begin
      failures++;
      $display("FAIL abort_next got=%h/%b want=%h/1", out_data, out_valid, pk(3, 3));
    end
    take();
  endtask

  task automatic test_reset_mid;
    beat(120, -120, 4);
    beat(100, -100, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid got=%h/%b/%b want=0000/0/1", out_data, out_valid, in_ready);
    end
`ifdef SAT_ACCUM_FLAG_EN
    checks++;
    if (sat_flag !== 2'b00) begin failures++; $display("FAIL rstmid_flag got=%b want=00", sat_flag); end
`endif
    beat(-3, 4, 2);
    beat(-4, 5, 2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== pk(-7, 9)) begin
      failures++;
      $display("FAIL rstmid_next got=%h/%b want=%h/1", out_data, out_valid, pk(-7, 9));
    end
    take();
  endtask

  task automatic test_back_to_back;
    beat(1, -128, 2);
    beat(3, -1, 2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== pk(4, -128)) begin
      failures++;
      $display("FAIL b2b_first got=%h/%b want=%h/1", out_data, out_valid, pk(4, -128));
    end
`ifdef SAT_ACCUM_FLAG_EN
    checks++;
    if (sat_flag !== 2'b10) begin failures++; $display("FAIL b2b_flag_set got=%b want=10", sat_flag); end
`endif
    take();
    beat(1, 1, 2);
    beat(1, 1, 2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== pk(2, 2)) begin
      failures++;
      $display("FAIL b2b_second got=%h/%b want=%h/1", out_data, out_valid, pk(2, 2));
    end
`ifdef SAT_ACCUM_FLAG_EN
    checks++;
    if (sat_flag !== 2'b00) begin failures++; $display("FAIL b2b_flag_clear got=%b want=00", sat_flag); end
`endif
    take();
  endtask

  initial begin
    test_reset();
    test_pos_sat();
    test_order();
    test_backpressure();
    test_len_zero();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
